spi_frame_tx: RTL and testbench

- Multi-channel SPI slave for streaming ADC samples to an external host.
- Buffers whole frames (one sample per channel) in a small FIFO.
- Shifts each frame out on MISO under host SCK/CS_N in a configurable SPI mode and bit order.
- Captures MOSI into SAMPLE_WIDTH-bit receive words for a future command path.
- Sits between the sample aggregator and the board SPI pins; all logic runs in the clk domain with oversampled SPI inputs.

---
 rtl/spi_frame_tx.sv | 201 ++++++++++++++++++++
 tb/tb_spi_frame_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI slave that streams buffered multi-channel sample frames out on
// MISO and assembles MOSI into receive words. The SPI pins are oversampled in clk.
module spi_frame_tx #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          CPOL         = 1'b0,
  parameter bit          CPHA         = 1'b0,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             underrun,
  output logic                             frame_abort,
  output logic [SAMPLE_WIDTH-1:0]          rx_data,
  output logic                             rx_valid,
  input  logic                             sck,
  input  logic                             cs_n,
  input  logic                             mosi,
  output logic                             miso
);

  localparam int unsigned FRAME_BITS = CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = $clog2(FRAME_BITS);
  localparam int unsigned RW         = $clog2(SAMPLE_WIDTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0] state;

  // Synchronisers and edge history
  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  // FIFO
  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, push, pop;
  logic [FRAME_BITS-1:0] head;

  // Transmit / receive datapath
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [CW-1:0]           bit_cnt, cnt_wrap;
  logic [SAMPLE_WIDTH-1:0] rx_sr, rx_word;
  logic [RW-1:0]           rx_cnt;

  logic sck_rise, sck_fall, lead_edge, trail_edge, shift_edge, sample_edge;
  logic cs_fall, cs_rise, frame_start;

  // Reorders a frame into transmit order: serial bit 0 sits in the top bit of the
  // result so the shift register only ever shifts left.
  function automatic logic [FRAME_BITS-1:0] serialize(input logic [FRAME_BITS-1:0] f);
    logic [FRAME_BITS-1:0] s;
    s = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      for (int unsigned b = 0; b < SAMPLE_WIDTH; b++) begin
        s[FRAME_BITS-1-(ch*SAMPLE_WIDTH+b)] = MSB_FIRST ? f[ch*SAMPLE_WIDTH+SAMPLE_WIDTH-1-b]
                                                        : f[ch*SAMPLE_WIDTH+b];
      end
    end
    return s;
  endfunction

  // Two-flop synchronisers; cs_n resets low so a CS_N held low through reset
  // produces no falling edge until it has been seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1  <= CPOL;
      sck_s2  <= CPOL;
      sck_d   <= CPOL;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Edge classification and frame-start decision
  always_comb begin
    sck_rise    = sck_s2 & ~sck_d;
    sck_fall    = ~sck_s2 & sck_d;
    lead_edge   = CPOL ? sck_fall : sck_rise;
    trail_edge  = CPOL ? sck_rise : sck_fall;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    sample_edge = CPHA ? trail_edge : lead_edge;
    cs_fall     = cs_d & ~cs_s2;
    cs_rise     = ~cs_d & cs_s2;
    cnt_wrap    = (bit_cnt == CW'(FRAME_BITS-1)) ? '0 : bit_cnt + 1'b1;
    frame_start = 1'b0;
    if (state == IDLE) begin
      frame_start = cs_fall & ~CPHA;
    end else if (!cs_rise && shift_edge) begin
      // CPHA=0 restarts on the edge that completes a frame; CPHA=1 starts on the
      // first leading edge of each frame, i.e. whenever the counter is at zero.
      frame_start = CPHA ? (bit_cnt == '0) : (bit_cnt == CW'(FRAME_BITS-1));
    end
  end

  // FIFO flags and handshake
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    in_ready = ~full;
    push     = in_valid & ~full;
    pop      = frame_start & ~empty;
    head     = mem[rd_ptr[AW-1:0]];
    rx_word  = MSB_FIRST ? {rx_sr[SAMPLE_WIDTH-2:0], mosi_s2}
                         : {mosi_s2, rx_sr[SAMPLE_WIDTH-1:1]};
    miso     = (state == ACTIVE) & tx_sr[FRAME_BITS-1];
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Transfer state machine, bit counter and transmit shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      underrun    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      underrun    <= frame_start & empty;
      frame_abort <= 1'b0;
      if (frame_start) tx_sr <= empty ? '0 : serialize(head);
      case (state)
        IDLE: begin
          if (cs_fall) state <= ACTIVE;
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            frame_abort <= (bit_cnt != '0);
          end else if (shift_edge) begin
            bit_cnt <= cnt_wrap;
            if (!frame_start) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MOSI receive word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == ACTIVE && cs_rise) begin
        rx_sr  <= '0;
        rx_cnt <= '0;
      end else if (state == ACTIVE && sample_edge) begin
        rx_sr <= rx_word;
        if (rx_cnt == RW'(SAMPLE_WIDTH-1)) begin
          rx_cnt   <= '0;
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: directed bench for spi_frame_tx, one instance in mode 0 MSB-first
// and one in mode 3 LSB-first, with bit-level MISO and word-level MOSI scoreboards.
module tb_spi_frame_tx;
  localparam int H = 8;  // SCK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] in_data0, in_data3;
  logic        in_valid0, in_ready0, underrun0, frame_abort0, rx_valid0;
  logic        in_valid3, in_ready3, underrun3, frame_abort3, rx_valid3;
  logic [15:0] rx_data0, rx_data3;
  logic        sck0, cs0, mosi0, miso0;
  logic        sck3, cs3, mosi3, miso3;

  int tests = 0;
  int fails = 0;
  int ur0 = 0, ur3 = 0, fa0 = 0, rxv0 = 0;
  logic        q0[$];
  logic        q3[$];
  logic [15:0] rxq[$];
  logic        rdy3_low;

  spi_frame_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4),
                 .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .underrun(underrun0), .frame_abort(frame_abort0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .sck(sck0), .cs_n(cs0), .mosi(mosi0), .miso(miso0));

  spi_frame_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4),
                 .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .underrun(underrun3), .frame_abort(frame_abort3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .sck(sck3), .cs_n(cs3), .mosi(mosi3), .miso(miso3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial order of a frame: channel 0 first, each sample MSB- or LSB-first.
  function automatic logic [31:0] order(input logic [31:0] f, input bit msb);
    logic [31:0] o;
    for (int p = 0; p < 32; p++) o[p] = msb ? f[(p/16)*16 + 15 - (p%16)] : f[p];
    return o;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enq0(input logic [31:0] f);
    logic [31:0] o;
    o = order(f, 1'b1);
    for (int p = 0; p < 32; p++) q0.push_back(o[p]);
  endtask

  task automatic enq3(input logic [31:0] f);
    logic [31:0] o;
    o = order(f, 1'b0);
    for (int p = 0; p < 32; p++) q3.push_back(o[p]);
  endtask

  task automatic push0(input logic [31:0] f);
    in_data0 = f; in_valid0 = 1'b1; wait_n(1); in_valid0 = 1'b0; enq0(f);
  endtask

  task automatic push3(input logic [31:0] f);
    in_data3 = f; in_valid3 = 1'b1; wait_n(1); in_valid3 = 1'b0; enq3(f);
  endtask

  // Mode 0 host: host samples MISO just before the rising edge, drives MOSI after falling.
  task automatic xfer0(input int nbits, input logic [15:0] mword);
    logic e;
    for (int i = 0; i < nbits; i++) begin
      mosi0 = mword[15 - (i % 16)];
      wait_n(H);
      e = (q0.size() > 0) ? q0.pop_front() : 1'bx;
      check($sformatf("miso0_bit%0d", i), 32'(miso0), 32'(e));
      sck0 = 1'b1;
      if (i % 16 == 15) rxq.push_back(mword);
      wait_n(H);
      sck0 = 1'b0;
    end
  endtask

  // Mode 3 host: leading edge falls, host samples MISO before the trailing rise.
  task automatic xfer3(input int nbits);
    logic e;
    for (int i = 0; i < nbits; i++) begin
      sck3 = 1'b0;
      wait_n(H);
      e = (q3.size() > 0) ? q3.pop_front() : 1'bx;
      check($sformatf("miso3_bit%0d", i), 32'(miso3), 32'(e));
      if (!in_ready3) rdy3_low = 1'b1;
      sck3 = 1'b1;
      wait_n(H);
    end
  endtask

  // Pulse counters
  always @(posedge clk) begin
    if (underrun0)    ur0  <= ur0 + 1;
    if (underrun3)    ur3  <= ur3 + 1;
    if (frame_abort0) fa0  <= fa0 + 1;
    if (rx_valid0)    rxv0 <= rxv0 + 1;
  end

  // Receive-word scoreboard
  always @(negedge clk) begin
    if (rx_valid0) begin
      if (rxq.size() == 0) check("rx_unexpected", 32'(rx_valid0), 32'd0);
      else check("rx_data", 32'(rx_data0), 32'(rxq.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u, f, n, r;
    rst = 1'b1;
    in_data0 = '0; in_valid0 = 1'b0; sck0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
    in_data3 = '0; in_valid3 = 1'b0; sck3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0;
    wait_n(4);
    rst = 1'b0;
    wait_n(4);

    // Reset state
    check("rst_in_ready0", 32'(in_ready0), 32'd1);
    check("rst_underrun0", 32'(underrun0), 32'd0);
    check("rst_abort0",    32'(frame_abort0), 32'd0);
    check("rst_rx_valid0", 32'(rx_valid0), 32'd0);
    check("rst_rx_data0",  32'(rx_data0), 32'd0);
    check("rst_miso0",     32'(miso0), 32'd0);
    check("rst_in_ready3", 32'(in_ready3), 32'd1);
    check("rst_miso3",     32'(miso3), 32'd0);

    // Mode 0 single frame
    push0(32'hA5A5_1234);
    u = ur0; f = fa0;
    cs0 = 1'b0;
    xfer0(32, 16'h0000);
    check("t1_no_underrun", 32'(ur0 - u), 32'd0);
    wait_n(H); cs0 = 1'b1; wait_n(H);
    check("t1_no_abort", 32'(fa0 - f), 32'd0);
    check("t1_miso_idle", 32'(miso0), 32'd0);

    // Mode 3 LSB-first, two frames back to back
    push3(32'h0F0F_8001);
    push3(32'h1357_C0DE);
    u = ur3;
    cs3 = 1'b0; wait_n(H);
    rdy3_low = 1'b0;
    xfer3(64);
    check("t2_in_ready_held", 32'(rdy3_low), 32'd0);
    check("t2_no_underrun", 32'(ur3 - u), 32'd0);
    wait_n(H); cs3 = 1'b1; wait_n(H);

    // Mode 3 with empty FIFO: zeros and a single underrun
    u = ur3;
    repeat (32) q3.push_back(1'b0);
    cs3 = 1'b0; wait_n(H);
    xfer3(32);
    wait_n(H); cs3 = 1'b1; wait_n(H);
    check("t3_underrun_once", 32'(ur3 - u), 32'd1);

    // Abort after 10 bits, then the next queued frame starts at bit 0
    push0(32'hDEAD_BEEF);
    push0(32'h0123_4567);
    f = fa0; r = rxv0;
    cs0 = 1'b0;
    xfer0(10, 16'h0000);
    wait_n(H); cs0 = 1'b1; wait_n(H);
    check("t4_abort_pulse", 32'(fa0 - f), 32'd1);
    check("t4_no_rx_partial", 32'(rxv0 - r), 32'd0);
    repeat (22) void'(q0.pop_front());
    cs0 = 1'b0;
    xfer0(32, 16'h0000);
    wait_n(H); cs0 = 1'b1; wait_n(H);

    // FIFO full with a fifth frame held, released by the next frame start
    push0(32'h1111_AAAA); check("t5_rdy1", 32'(in_ready0), 32'd1);
    push0(32'h2222_BBBB); check("t5_rdy2", 32'(in_ready0), 32'd1);
    push0(32'h3333_CCCC); check("t5_rdy3", 32'(in_ready0), 32'd1);
    push0(32'h4444_DDDD); check("t5_rdy4", 32'(in_ready0), 32'd0);
    in_data0 = 32'h5555_EEEE; in_valid0 = 1'b1;
    wait_n(4);
    check("t5_full_hold", 32'(in_ready0), 32'd0);
    cs0 = 1'b0;
    n = 0;
    while (!in_ready0 && n < 20) begin wait_n(1); n++; end
    check("t5_ready_latency", 32'(n), 32'd3);
    wait_n(1); in_valid0 = 1'b0; enq0(32'h5555_EEEE);
    xfer0(160, 16'h5A3C);
    wait_n(H); cs0 = 1'b1; wait_n(H);
    check("t5_ready_after", 32'(in_ready0), 32'd1);

    // Receive word, then a 7-bit abort that must not produce rx_valid
    r = rxv0;
    repeat (16) q0.push_back(1'b0);
    cs0 = 1'b0;
    xfer0(16, 16'hC3F0);
    wait_n(H);
    check("t6_rx_one_pulse", 32'(rxv0 - r), 32'd1);
    check("t6_rx_drained", 32'(rxq.size()), 32'd0);
    cs0 = 1'b1; wait_n(H);
    r = rxv0;
    repeat (7) q0.push_back(1'b0);
    cs0 = 1'b0;
    xfer0(7, 16'hFFFF);
    wait_n(H); cs0 = 1'b1; wait_n(H);
    check("t6_abort_no_rx", 32'(rxv0 - r), 32'd0);
    check("t6_rx_data_hold", 32'(rx_data0), 32'h0000_C3F0);

    // Reset with CS_N held low: ignored until a fresh falling edge
    cs0 = 1'b0; wait_n(H);
    rst = 1'b1; wait_n(2); rst = 1'b0;
    push0(32'h6789_ABCD);
    u = ur0;
    wait_n(20);
    check("t7_held_low_miso", 32'(miso0), 32'd0);
    check("t7_held_low_no_start", 32'(ur0 - u), 32'd0);
    cs0 = 1'b1; wait_n(H);
    cs0 = 1'b0;
    xfer0(32, 16'h0000);
    wait_n(H); cs0 = 1'b1; wait_n(H);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
